// File: rtl/alu_pkg.sv
// Shared RV32I ALU definitions: datapath width and op-code encodings.
// Imported by the ALU, decoder and control logic.
package alu_pkg;

   localparam int ALU_XLEN = 32;
   localparam int ALU_SHW  = $clog2(ALU_XLEN);

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b1000;
   localparam logic [3:0] ALU_LSL    = 4'b0001;
   localparam logic [3:0] ALU_LT     = 4'b0010;
   localparam logic [3:0] ALU_LTU    = 4'b0011;
   localparam logic [3:0] ALU_XOR    = 4'b0100;
   localparam logic [3:0] ALU_LSR    = 4'b0101;
   localparam logic [3:0] ALU_ASR    = 4'b1101;
   localparam logic [3:0] ALU_OR     = 4'b0110;
   localparam logic [3:0] ALU_AND    = 4'b0111;
   localparam logic [3:0] ALU_PASS_1 = 4'b1111;

   // Compares reuse the subtractor, so they also need the inverted B operand.
   function automatic logic alu_uses_sub(input logic [3:0] op);
      return (op == ALU_SUB) || (op == ALU_LT) || (op == ALU_LTU);
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter for LSL/LSR/ASR.
// Left shifts are done as right shifts on a bit-reversed operand.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int XLEN = ALU_XLEN,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic [XLEN-1:0] data_i,
   input  logic [SHW-1:0]  shamt_i,
   input  logic            left_i,
   input  logic            arith_i,
   output logic [XLEN-1:0] result_o
);

   logic [XLEN-1:0]         data_rev;
   logic [XLEN-1:0]         res_rev;
   logic [SHW:0][XLEN-1:0]  stage;
   logic                    fill;

   always_comb begin
      data_rev = '0;
      res_rev  = '0;
      for (int i = 0; i < XLEN; i++) begin
         data_rev[i] = data_i[XLEN-1-i];
         res_rev[i]  = stage[SHW][XLEN-1-i];
      end
   end

   assign fill     = arith_i & ~left_i & data_i[XLEN-1];
   assign stage[0] = left_i ? data_rev : data_i;

   // Stage g shifts right by 2**g when shamt bit g is set.
   for (genvar g = 0; g < SHW; g++) begin : g_stage
      localparam int D = 1 << g;
      assign stage[g+1] = shamt_i[g] ? {{D{fill}}, stage[g][XLEN-1:D]} : stage[g];
   end

   assign result_o = left_i ? res_rev : stage[SHW];

endmodule

// File: rtl/rv32_alu.sv
// RV32I execute-stage integer ALU: combinational result/zero flag plus
// registered copies for downstream pipeline and branch logic.
module rv32_alu
   import alu_pkg::*;
#(
   parameter int XLEN = ALU_XLEN,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] in_0,
   input  logic [XLEN-1:0] in_1,
   input  logic [3:0]      operation,
   input  logic            inv_zero,
   output logic [XLEN-1:0] out,
   output logic            zero,
   output logic [XLEN-1:0] out_q,
   output logic            zero_q
);

   logic            sub_en;
   logic [XLEN-1:0] b_op;
   logic [XLEN-1:0] sum;
   logic            carry;
   logic            ovf;
   logic            lt_s;
   logic            lt_u;
   logic [XLEN-1:0] shift_res;
   logic            shift_left;
   logic            shift_arith;
   logic [XLEN-1:0] out_d;
   logic            zero_d;

   // Shared adder: subtract is A + ~B + 1, carry-out set means no borrow.
   assign sub_en       = alu_uses_sub(operation);
   assign b_op         = sub_en ? ~in_1 : in_1;
   assign {carry, sum} = {1'b0, in_0} + {1'b0, b_op} + {{XLEN{1'b0}}, sub_en};

   assign ovf  = (in_0[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != in_0[XLEN-1]);
   assign lt_s = sum[XLEN-1] ^ ovf;
   assign lt_u = ~carry;

   assign shift_left  = (operation == ALU_LSL);
   assign shift_arith = (operation == ALU_ASR);

   alu_shifter #(
      .XLEN (XLEN),
      .SHW  (SHW)
   ) u_shifter (
      .data_i   (in_0),
      .shamt_i  (in_1[SHW-1:0]),
      .left_i   (shift_left),
      .arith_i  (shift_arith),
      .result_o (shift_res)
   );

   always_comb begin
      out = '0;
      case (operation)
         ALU_ADD,
         ALU_SUB:    out = sum;
         ALU_LSL,
         ALU_LSR,
         ALU_ASR:    out = shift_res;
         ALU_LT:     out = {{(XLEN-1){1'b0}}, lt_s};
         ALU_LTU:    out = {{(XLEN-1){1'b0}}, lt_u};
         ALU_XOR:    out = in_0 ^ in_1;
         ALU_OR:     out = in_0 | in_1;
         ALU_AND:    out = in_0 & in_1;
         ALU_PASS_1: out = in_1;
         default:    out = '0;
      endcase
   end

   assign zero   = (out == '0) ^ inv_zero;
   assign out_d  = out;
   assign zero_d = zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         zero_q <= zero_d;
      end
   end

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu: per-feature vector tables, combinational
// checks inline, registered outputs checked through an expectation queue.
module tb_rv32_alu;

   localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_LSL = 4'b0001;
   localparam logic [3:0] OP_LT  = 4'b0010, OP_LTU = 4'b0011, OP_XOR = 4'b0100;
   localparam logic [3:0] OP_LSR = 4'b0101, OP_ASR = 4'b1101, OP_OR  = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0111, OP_P1  = 4'b1111;

   typedef struct packed {
      logic [31:0] o;
      logic        z;
   } exp_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        inv;
      logic        rst;
      logic [31:0] o;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_0, in_1;
   logic [3:0]  operation;
   logic        inv_zero;
   logic [31:0] out, out_q;
   logic        zero, zero_q;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   rv32_alu dut (
      .clk       (clk),
      .rst       (rst),
      .in_0      (in_0),
      .in_1      (in_1),
      .operation (operation),
      .inv_zero  (inv_zero),
      .out       (out),
      .zero      (zero),
      .out_q     (out_q),
      .zero_q    (zero_q)
   );

   // Runs a table: combinational check before the edge, registered check after.
   task automatic run_table(input string name, input vec_t v[$]);
      exp_t e, got;
      for (int i = 0; i < v.size(); i++) begin
         rst = v[i].rst; operation = v[i].op; in_0 = v[i].a; in_1 = v[i].b; inv_zero = v[i].inv;
         #1;
         e.o = v[i].o;
         e.z = (v[i].o == 32'd0) ^ v[i].inv;
         n_cmp++;
         if (out !== e.o || zero !== e.z) begin
            n_bad++;
            $display("FAIL %s[%0d] comb: got out=%h zero=%b, want out=%h zero=%b",
                     name, i, out, zero, e.o, e.z);
         end
         if (v[i].rst) sb_q.push_back('{o: 32'd0, z: 1'b0});
         else          sb_q.push_back(e);
         @(posedge clk); #1;
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s[%0d] reg: scoreboard empty, got out_q=%h", name, i, out_q);
         end else begin
            got = sb_q.pop_front();
            if (out_q !== got.o || zero_q !== got.z) begin
               n_bad++;
               $display("FAIL %s[%0d] reg: got out_q=%h zero_q=%b, want out_q=%h zero_q=%b",
                        name, i, out_q, zero_q, got.o, got.z);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; operation = OP_ADD; in_0 = 32'd5; in_1 = 32'd7; inv_zero = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_q !== 32'd0 || zero_q !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: got out_q=%h zero_q=%b, want 0/0", out_q, zero_q);
      end
      n_cmp++;
      if (out !== 32'd12) begin
         n_bad++;
         $display("FAIL reset_comb: got out=%h during rst, want 0000000c", out);
      end
      rst = 1'b0;
   endtask

   task automatic test_arith();
      vec_t v[$];
      v.push_back('{OP_ADD, 32'd5,           32'd7,           1'b0, 1'b0, 32'd12});
      v.push_back('{OP_ADD, 32'hFFFF_FFFE,   32'd7,           1'b0, 1'b0, 32'd5});
      v.push_back('{OP_SUB, 32'd5,           32'd7,           1'b0, 1'b0, 32'hFFFF_FFFE});
      v.push_back('{OP_SUB, 32'hFFFF_FFFE,   32'hFFFF_FFF9,   1'b0, 1'b0, 32'd5});
      v.push_back('{OP_SUB, 32'd15,          32'd0,           1'b0, 1'b0, 32'd15});
      v.push_back('{OP_ADD, 32'hFFFF_FFFF,   32'd1,           1'b0, 1'b0, 32'd0});
      run_table("arith", v);
   endtask

   task automatic test_logic();
      vec_t v[$];
      v.push_back('{OP_XOR, 32'd5,  32'd6,         1'b0, 1'b0, 32'd3});
      v.push_back('{OP_XOR, 32'd10, 32'd3,         1'b0, 1'b0, 32'd9});
      v.push_back('{OP_OR,  32'd11, 32'hFFFF_FFF5, 1'b0, 1'b0, 32'hFFFF_FFFF});
      v.push_back('{OP_AND, 32'd10, 32'd3,         1'b0, 1'b0, 32'd2});
      v.push_back('{OP_P1,  32'd8,  32'd14,        1'b0, 1'b0, 32'd14});
      run_table("logic", v);
   endtask

   task automatic test_shift();
      vec_t v[$];
      v.push_back('{OP_LSR, 32'd10,          32'd3,  1'b0, 1'b0, 32'd1});
      v.push_back('{OP_LSR, 32'hFFFF_FFFF,   32'd3,  1'b0, 1'b0, 32'h1FFF_FFFF});
      v.push_back('{OP_LSL, 32'd5,           32'd3,  1'b0, 1'b0, 32'd40});
      v.push_back('{OP_ASR, 32'hFFFF_FFF6,   32'd3,  1'b0, 1'b0, 32'hFFFF_FFFE});
      v.push_back('{OP_ASR, 32'hFFFF_FFFF,   32'd37, 1'b0, 1'b0, 32'hFFFF_FFFF});
      v.push_back('{OP_ASR, 32'h8000_0000,   32'd37, 1'b0, 1'b0, 32'hFC00_0000});
      v.push_back('{OP_LSL, 32'd1,           32'd31, 1'b0, 1'b0, 32'h8000_0000});
      v.push_back('{OP_LSR, 32'h8000_0000,   32'd31, 1'b0, 1'b0, 32'd1});
      v.push_back('{OP_LSL, 32'h1234_5678,   32'd48, 1'b0, 1'b0, 32'h5678_0000});
      run_table("shift", v);
   endtask

   task automatic test_compare();
      vec_t v[$];
      v.push_back('{OP_LT,  32'd10,          32'd3,           1'b0, 1'b0, 32'd0});
      v.push_back('{OP_LT,  32'hFFFF_FFF6,   32'd3,           1'b0, 1'b0, 32'd1});
      v.push_back('{OP_LT,  32'hFFFF_FFFE,   32'hFFFF_FFFD,   1'b0, 1'b0, 32'd0});
      v.push_back('{OP_LT,  32'h8000_0000,   32'd1,           1'b0, 1'b0, 32'd1});
      v.push_back('{OP_LT,  32'h7FFF_FFFF,   32'hFFFF_FFFF,   1'b0, 1'b0, 32'd0});
      v.push_back('{OP_LTU, 32'hFFFF_FFF6,   32'd3,           1'b0, 1'b0, 32'd0});
      v.push_back('{OP_LTU, 32'd5,           32'hFFFF_FFFD,   1'b0, 1'b0, 32'd1});
      v.push_back('{OP_LTU, 32'hFFFF_FFFE,   32'hFFFF_FFFD,   1'b0, 1'b0, 32'd0});
      v.push_back('{OP_LTU, 32'd7,           32'd7,           1'b0, 1'b0, 32'd0});
      run_table("compare", v);
   endtask

   task automatic test_flag();
      vec_t v[$];
      v.push_back('{OP_SUB,  32'd7, 32'd7, 1'b0, 1'b0, 32'd0});
      v.push_back('{OP_SUB,  32'd7, 32'd7, 1'b1, 1'b0, 32'd0});
      v.push_back('{4'b1001, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0});
      v.push_back('{4'b1010, 32'd5, 32'd7, 1'b1, 1'b0, 32'd0});
      v.push_back('{OP_ADD,  32'd1, 32'd2, 1'b1, 1'b0, 32'd3});
      run_table("flag", v);
   endtask

   task automatic test_back_to_back();
      vec_t v[$];
      v.push_back('{OP_ADD, 32'd5,  32'd7, 1'b0, 1'b0, 32'd12});
      v.push_back('{OP_XOR, 32'd10, 32'd3, 1'b0, 1'b0, 32'd9});
      v.push_back('{OP_ADD, 32'd1,  32'd1, 1'b0, 1'b1, 32'd2});
      v.push_back('{OP_SUB, 32'd4,  32'd4, 1'b0, 1'b0, 32'd0});
      v.push_back('{OP_OR,  32'd8,  32'd1, 1'b1, 1'b0, 32'd9});
      run_table("b2b", v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; operation = OP_ADD; in_0 = '0; in_1 = '0; inv_zero = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_arith();
      test_logic();
      test_shift();
      test_compare();
      test_flag();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
